// File: rtl/argmax_pkg.sv
// argmax_pkg: shared constants, state encoding and FP32 ordering helpers for
// the classifier argmax controller and its PE.
//   N_CLASS       number of logits per inference
//   PE_LAT        cycles the PE is held out of reset per pass
//   CLASS_INVALID class code reported when the PE finds no winner
package argmax_pkg;

  localparam int unsigned N_CLASS       = 10;
  localparam int unsigned PE_LAT        = 8;
  localparam logic [3:0]  CLASS_INVALID = 4'hF;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRun  = 3'd2,
    StCapt = 3'd3,
    StDone = 3'd4
  } argmax_state_t;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Maps an FP32 pattern onto an unsigned key with the same ordering as the
  // float value (negatives are bit-inverted, positives get the MSB set).
  function automatic logic [31:0] fp_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

endpackage

// File: rtl/argmax_ctrl_pe_findamx.sv
// PE_findamx: two-stage pipelined argmax over ten FP32 values.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset; clears the pipeline
//   in_0..in_9   FP32 candidates, must be stable while out of reset
//   out          winning index 0..9; 4'hF until the pipeline has filled or
//                when every input is NaN
// NaN inputs never win. On equal values the lowest index wins.
module PE_findamx
  import argmax_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_0,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  input  logic [31:0] in_3,
  input  logic [31:0] in_4,
  input  logic [31:0] in_5,
  input  logic [31:0] in_6,
  input  logic [31:0] in_7,
  input  logic [31:0] in_8,
  input  logic [31:0] in_9,
  output logic [3:0]  out
);

  localparam int unsigned HALF = 5;

  logic [31:0] in_arr [10];

  assign in_arr[0] = in_0;
  assign in_arr[1] = in_1;
  assign in_arr[2] = in_2;
  assign in_arr[3] = in_3;
  assign in_arr[4] = in_4;
  assign in_arr[5] = in_5;
  assign in_arr[6] = in_6;
  assign in_arr[7] = in_7;
  assign in_arr[8] = in_8;
  assign in_arr[9] = in_9;

  // Stage 1: independent scan of each half.
  logic [1:0]       h_found;
  logic [1:0][3:0]  h_idx;
  logic [1:0][31:0] h_key;

  always_comb begin
    h_found = '0;
    h_idx   = {CLASS_INVALID, CLASS_INVALID};
    h_key   = '0;
    for (int h = 0; h < 2; h++) begin
      for (int i = h * HALF; i < (h + 1) * HALF; i++) begin
        // Strict greater-than keeps the earlier index on ties.
        if (!fp_is_nan(in_arr[i]) && (!h_found[h] || (fp_key(in_arr[i]) > h_key[h]))) begin
          h_found[h] = 1'b1;
          h_idx[h]   = 4'(i);
          h_key[h]   = fp_key(in_arr[i]);
        end
      end
    end
  end

  logic [1:0]       s1_found_q;
  logic [1:0][3:0]  s1_idx_q;
  logic [1:0][31:0] s1_key_q;
  logic             s1_valid_q;
  logic [3:0]       s2_idx_q, s2_idx_d;
  logic             s2_valid_q;

  // Stage 2: lower half wins unless the upper half is strictly larger.
  // With no winner in either half, s1_idx_q[0] already holds CLASS_INVALID.
  always_comb begin
    s2_idx_d = s1_idx_q[0];
    if (s1_found_q[1] && (!s1_found_q[0] || (s1_key_q[1] > s1_key_q[0]))) begin
      s2_idx_d = s1_idx_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_found_q <= '0;
      s1_idx_q   <= {CLASS_INVALID, CLASS_INVALID};
      s1_key_q   <= '0;
      s1_valid_q <= 1'b0;
      s2_idx_q   <= CLASS_INVALID;
      s2_valid_q <= 1'b0;
    end else begin
      s1_found_q <= h_found;
      s1_idx_q   <= h_idx;
      s1_key_q   <= h_key;
      s1_valid_q <= 1'b1;
      s2_idx_q   <= s2_idx_d;
      s2_valid_q <= s1_valid_q;
    end
  end

  assign out = s2_valid_q ? s2_idx_q : CLASS_INVALID;

endmodule

// File: rtl/argmax_ctrl.sv
// argmax_ctrl: buffers ten FP32 logits from a valid/ready stream, runs one
// PE_findamx pass by releasing its reset for PE_LAT cycles, and presents the
// winning class on a valid/ready result port.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    logit handshake, in_data is the logit (class 0..9)
//   res_valid/res_ready  result handshake
//   res_class            winning class, 4'hF on PE failure
//   res_err              high when res_class is 4'hF
//   busy                 high whenever the controller is not idle
//   err_cnt, err_clr     only with ARGMAX_ERR_CNT_EN: saturating count of
//                        failed passes, and its synchronous clear
module argmax_ctrl
  import argmax_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_class,
  output logic              res_err,
`ifdef ARGMAX_ERR_CNT_EN
  output logic [7:0]        err_cnt,
  input  logic              err_clr,
`endif
  output logic              busy
);

  localparam logic [3:0] LAST_IDX = 4'(N_CLASS - 1);
  localparam logic [3:0] RUN_LAST = 4'(PE_LAT - 1);

  argmax_state_t     state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        run_cnt_q, run_cnt_d;
  logic [3:0]        res_class_q, res_class_d;
  logic              res_err_q, res_err_d;
  logic [DATA_W-1:0] logit_q [N_CLASS];
  logic [DATA_W-1:0] logit_d [N_CLASS];
  logic              accept;
  logic              pe_rst;
  logic [3:0]        pe_out;

  assign in_ready  = (state_q == StIdle) || (state_q == StLoad);
  assign res_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign accept    = in_valid && in_ready;
  assign res_class = res_class_q;
  assign res_err   = res_err_q;

  // The PE restarts from a clean pipeline on every pass.
  assign pe_rst = rst || (state_q != StRun);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_cnt_d   = run_cnt_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;
    logit_d     = logit_q;

    // idx_q is 0 in IDLE, so the first accept lands in logit[0].
    if (accept) begin
      logit_d[idx_q] = in_data;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d   = 4'd1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            run_cnt_d = '0;
            state_d   = StRun;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StRun: begin
        run_cnt_d = run_cnt_q + 4'd1;
        if (run_cnt_q == RUN_LAST) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        res_class_d = pe_out;
        res_err_d   = (pe_out == CLASS_INVALID);
        state_d     = StDone;
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      run_cnt_q   <= '0;
      res_class_q <= CLASS_INVALID;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_cnt_q   <= run_cnt_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
    end
  end

  // Logit buffer carries no reset; its contents are only used after a full load.
  always_ff @(posedge clk) begin
    logit_q <= logit_d;
  end

`ifdef ARGMAX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if ((state_q == StCapt) && (pe_out == CLASS_INVALID) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  PE_findamx u_pe (
    .clk  (clk),
    .rst  (pe_rst),
    .in_0 (logit_q[0]),
    .in_1 (logit_q[1]),
    .in_2 (logit_q[2]),
    .in_3 (logit_q[3]),
    .in_4 (logit_q[4]),
    .in_5 (logit_q[5]),
    .in_6 (logit_q[6]),
    .in_7 (logit_q[7]),
    .in_8 (logit_q[8]),
    .in_9 (logit_q[9]),
    .out  (pe_out)
  );

endmodule

// File: tb/tb_argmax_ctrl.sv
// tb_argmax_ctrl: self-checking bench for argmax_ctrl. Vector table of logit
// sets driven through the stream port, expected results queued on the tenth
// accept and compared at the result handshake, plus reset corner sequences.
module tb_argmax_ctrl;
  import argmax_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_class;
  logic        res_err;
  logic        busy;
`ifdef ARGMAX_ERR_CNT_EN
  logic [7:0]  err_cnt;
  logic        err_clr;
  int          exp_err_cnt = 0;
`endif

  always #5 clk = ~clk;

  argmax_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
    .res_err   (res_err),
`ifdef ARGMAX_ERR_CNT_EN
    .err_cnt   (err_cnt),
    .err_clr   (err_clr),
`endif
    .busy      (busy)
  );

  typedef struct {
    int          max_cls;
    logic [31:0] max_val;
    logic [31:0] oth_val;
    int          nan_cls;
    bit          gap;
    int          hold;
    logic [3:0]  exp_cls;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] cls;
    logic       err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  function automatic vec_t mk_vec(input int mc, input logic [31:0] mv, input logic [31:0] ov,
                                  input int nc, input bit g, input int h,
                                  input logic [3:0] ec, input logic ee);
    vec_t v;
    v.max_cls = mc; v.max_val = mv; v.oth_val = ov; v.nan_cls = nc;
    v.gap = g; v.hold = h; v.exp_cls = ec; v.exp_err = ee;
    return v;
  endfunction

  function automatic logic [31:0] logit_for(input vec_t v, input int c);
    if (c == v.max_cls) return v.max_val;
    if (c == v.nan_cls) return 32'h7FC00000;
    return v.oth_val;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    res_ready = 1'b0;
    tick();
    rst = 1'b0;
`ifdef ARGMAX_ERR_CNT_EN
    exp_err_cnt = 0;
`endif
  endtask

  task automatic send_set(input vec_t v, input bit push, output int t_first, output int t_last);
    exp_t e;
    t_first = 0;
    t_last  = 0;
    for (int c = 0; c < 10; c++) begin
      if (v.gap && (c != 0)) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = logit_for(v, c);
      check("in_ready on beat", in_ready, 1);
      if (c == 0) t_first = cyc;
      if (c == 9) begin
        t_last = cyc;
        if (push) begin
          e.cls = v.exp_cls;
          e.err = v.exp_err;
          sb.push_back(e);
        end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    int   t1, t9, lat;
    exp_t e;
    send_set(v, 1'b1, t1, t9);
    check("load span", t9 - t1 + 1, v.gap ? 19 : 10);
    res_ready = (v.hold == 0);
    lat = 1;
    while (!res_valid && lat < 30) begin
      check("busy while running", busy, 1);
      check("in_ready while running", in_ready, 0);
      tick();
      lat++;
    end
    if (!res_valid) begin
      check("res_valid timeout", res_valid, 1);
      return;
    end
    check("result latency", lat, 10);
    // Logits offered while DONE must be ignored.
    in_valid = 1'b1;
    in_data  = 32'h7F7FFFFF;
    for (int k = 0; k < v.hold; k++) begin
      check("res_valid held", res_valid, 1);
      check("res_class held", res_class, v.exp_cls);
      check("in_ready low in DONE", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    if (sb.size() == 0) begin
      check("scoreboard underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      check("res_class", res_class, e.cls);
      check("res_err", res_err, e.err);
`ifdef ARGMAX_ERR_CNT_EN
      if (e.err) exp_err_cnt++;
`endif
    end
    tick();
    res_ready = 1'b0;
    check("in_ready after handshake", in_ready, 1);
    check("res_valid after handshake", res_valid, 0);
    check("busy after handshake", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t1, t9, seen;
    vec_t v;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    res_ready = 1'b0;
`ifdef ARGMAX_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    check("reset in_ready", in_ready, 1);
    check("reset res_valid", res_valid, 0);
    check("reset res_class", res_class, 4'hF);
    check("reset res_err", res_err, 0);
    check("reset busy", busy, 0);
`ifdef ARGMAX_ERR_CNT_EN
    check("reset err_cnt", err_cnt, 0);
`endif

    vecs[0] = mk_vec(6, 32'h40A00000, 32'h3F800000, -1, 1'b0, 0, 4'd6, 1'b0);
    vecs[1] = mk_vec(0, 32'h40000000, 32'hBF800000, -1, 1'b1, 0, 4'd0, 1'b0);
    vecs[2] = mk_vec(9, 32'h40400000, 32'h3F800000, -1, 1'b0, 5, 4'd9, 1'b0);
    vecs[3] = mk_vec(3, 32'hBF800000, 32'hC0000000, -1, 1'b0, 2, 4'd3, 1'b0);
    vecs[4] = mk_vec(5, 32'h40800000, 32'h3F800000, 7, 1'b0, 0, 4'd5, 1'b0);
    vecs[5] = mk_vec(0, 32'h7FC00000, 32'h7FC00000, -1, 1'b0, 1, 4'hF, 1'b1);
    vecs[6] = mk_vec(2, 32'h3F800000, 32'h3F800000, -1, 1'b1, 0, 4'd0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      run_case(vecs[i]);
    end

    // Partial load then reset: the next full set must land from class 0.
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = (c == 1) ? 32'h41100000 : 32'h3F000000;
      tick();
    end
    in_valid = 1'b0;
    check("busy mid-load", busy, 1);
    do_reset();
    check("busy after mid-load reset", busy, 0);
    check("in_ready after mid-load reset", in_ready, 1);
    run_case(mk_vec(3, 32'h40400000, 32'h3F800000, -1, 1'b0, 0, 4'd3, 1'b0));

    // Reset during RUN cycle 4 aborts the pass with no result.
    v = mk_vec(8, 32'h40A00000, 32'h3F800000, -1, 1'b0, 0, 4'd8, 1'b0);
    send_set(v, 1'b0, t1, t9);
    tick();
    tick();
    tick();
    check("busy in RUN", busy, 1);
    do_reset();
    check("busy after RUN reset", busy, 0);
    check("res_valid after RUN reset", res_valid, 0);
    check("res_class after RUN reset", res_class, 4'hF);
    res_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (res_valid) seen++;
      tick();
    end
    res_ready = 1'b0;
    check("no result after aborted pass", seen, 0);

`ifdef ARGMAX_ERR_CNT_EN
    run_case(vecs[5]);
    run_case(vecs[5]);
    check("err_cnt after two failures", err_cnt, exp_err_cnt);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cnt after clear", err_cnt, 0);
`endif

    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
